// File: rtl/instr_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_pkg
// Shared definitions for the instruction fetch unit and the blocks it talks to
// (instruction RAM, control unit).
//   fetch_state_e        : fetch FSM states
//   FETCH_IDLE/FETCH_READ: encodings of the FETCH strobe into the RAM
//   DEFAULT_HALT_OPCODE  : opcode that stops fetching once consumed
//   DEFAULT_RESET_PC     : program counter after reset / restart
//   fetchCodeFor()       : FETCH strobe value that belongs to a given state
// -----------------------------------------------------------------------------
package instr_fetch_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_VALID = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_e;

    localparam logic [1:0] FETCH_IDLE = 2'b00;
    localparam logic [1:0] FETCH_READ = 2'b01;

    localparam logic [7:0] DEFAULT_HALT_OPCODE = 8'hFF;
    localparam logic [7:0] DEFAULT_RESET_PC    = 8'h00;

    // The read strobe is only ever raised while the FSM sits in REQ, which
    // guarantees one strobe per instruction and never an illegal 2'b1x code.
    function automatic logic [1:0] fetchCodeFor(input fetch_state_e s);
        return (s == ST_REQ) ? FETCH_READ : FETCH_IDLE;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Bundles the instruction-RAM bus and the decode handshake of the fetch unit.
//   start      : begin / restart fetching (control -> fetch)
//   instr_in   : byte returned by the instruction RAM
//   ir_ack     : decode consumed ir this cycle
//   jump_en    : with ir_ack, redirect the next fetch to jump_addr
//   jump_addr  : jump target
//   iAddr      : registered address to the instruction RAM
//   FETCH      : registered read strobe (2'b01 read, 2'b00 idle)
//   ir         : instruction register
//   ir_valid   : ir holds an unconsumed instruction
//   pc         : address of the next instruction to fetch
//   halted     : fetch is stopped
// master = fetch unit side, slave = environment (RAM + decode + control).
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);

    logic              start;
    logic [DATA_W-1:0] instr_in;
    logic              ir_ack;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;
    logic [ADDR_W-1:0] iAddr;
    logic [1:0]        FETCH;
    logic [DATA_W-1:0] ir;
    logic              ir_valid;
    logic [ADDR_W-1:0] pc;
    logic              halted;

    modport master (
        input  start, instr_in, ir_ack, jump_en, jump_addr,
        output iAddr, FETCH, ir, ir_valid, pc, halted
    );

    modport slave (
        output start, instr_in, ir_ack, jump_en, jump_addr,
        input  iAddr, FETCH, ir, ir_valid, pc, halted
    );

endinterface

// File: rtl/instr_fetch_unit_pc_reg.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_pc_reg
// Program counter register with load / increment / hold.
//   clk, rst    : clock, asynchronous active-high reset (to RESET_PC)
//   load_i      : load loadVal_i (has priority over inc_i)
//   loadVal_i   : value to load
//   inc_i       : increment by one, wrapping modulo 2^ADDR_W
//   pc_o        : current program counter
//   pcNext_o    : value the counter takes on the next edge
//   atTop_o     : counter sits at the last address (all ones)
// -----------------------------------------------------------------------------
module instr_fetch_unit_pc_reg #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] loadVal_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pcNext_o,
    output logic              atTop_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Next value is exported so the owner can copy it into iAddr on the same
    // edge a jump or restart lands, without waiting a cycle for pc_q.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = loadVal_i;
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o     = pc_q;
    assign pcNext_o = pc_d;
    assign atTop_o  = (pc_q == {ADDR_W{1'b1}});

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Requester side of the instruction-memory fetch path. Holds the PC, issues a
// one-cycle read strobe to the instruction RAM, captures the returned byte into
// the instruction register and offers it to decode with a valid/ack handshake.
// Handles jumps from decode, the HALT opcode and end-of-memory behaviour.
//   clk, rst  : clock, asynchronous active-high reset
//   fetchBus  : instr_fetch_unit_if.master (RAM bus + decode handshake)
// Parameters: ADDR_W, DATA_W, RESET_PC, HALT_OPCODE,
//             WRAP_EN (1: PC wraps past the last address, 0: halt there).
// One instruction takes REQ -> WAIT -> VALID, i.e. at best one per 3 clocks.
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W      = 8,
    parameter int                DATA_W      = 8,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEFAULT_RESET_PC),
    parameter logic [DATA_W-1:0] HALT_OPCODE = DATA_W'(DEFAULT_HALT_OPCODE),
    parameter bit                WRAP_EN     = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_unit_if.master  fetchBus
);

    fetch_state_e state_q;
    fetch_state_e state_d;

    logic [ADDR_W-1:0] iAddr_q;
    logic [ADDR_W-1:0] iAddr_d;
    logic [1:0]        fetch_q;
    logic [1:0]        fetch_d;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] ir_d;
    logic              irValid_q;
    logic              irValid_d;
    logic              haltPend_q;
    logic              haltPend_d;
    logic              halted_q;
    logic              halted_d;

    logic              pcLoad;
    logic [ADDR_W-1:0] pcLoadVal;
    logic              pcInc;
    logic [ADDR_W-1:0] pcCur;
    logic [ADDR_W-1:0] pcNext;
    logic              pcAtTop;
    logic              captureHalts;

    instr_fetch_unit_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) pcReg (
        .clk       (clk),
        .rst       (rst),
        .load_i    (pcLoad),
        .loadVal_i (pcLoadVal),
        .inc_i     (pcInc),
        .pc_o      (pcCur),
        .pcNext_o  (pcNext),
        .atTop_o   (pcAtTop)
    );

    // State register. Reset drops any in-flight fetch: the FSM returns to
    // IDLE, so the RAM's late data is never captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A pending halt only takes effect when decode acks
    // without a jump; a jump overrides it and fetching carries on.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (fetchBus.start) state_d = ST_REQ;
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                state_d = ST_VALID;
            end
            ST_VALID: begin
                if (fetchBus.ir_ack) begin
                    state_d = (haltPend_q && !fetchBus.jump_en) ? ST_HALT : ST_REQ;
                end
            end
            ST_HALT: begin
                if (fetchBus.start) state_d = ST_REQ;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The captured byte ends fetching if it is the halt opcode, or if it came
    // from the last address while wrap-around is disabled; either way the PC
    // stays on that address.
    assign captureHalts = (fetchBus.instr_in == HALT_OPCODE) || (pcAtTop && !WRAP_EN);

    // Output / datapath control: instruction register, handshake flag, halt
    // bookkeeping and PC load/increment, all decided from the current state.
    always_comb begin
        ir_d       = ir_q;
        irValid_d  = irValid_q;
        haltPend_d = haltPend_q;
        pcLoad     = 1'b0;
        pcLoadVal  = pcCur;
        pcInc      = 1'b0;
        case (state_q)
            ST_WAIT: begin
                ir_d      = fetchBus.instr_in;
                irValid_d = 1'b1;
                if (captureHalts) begin
                    haltPend_d = 1'b1;
                end else begin
                    pcInc = 1'b1;
                end
            end
            ST_VALID: begin
                if (fetchBus.ir_ack) begin
                    irValid_d = 1'b0;
                    if (fetchBus.jump_en) begin
                        pcLoad     = 1'b1;
                        pcLoadVal  = fetchBus.jump_addr;
                        haltPend_d = 1'b0;
                    end
                end
            end
            ST_HALT: begin
                if (fetchBus.start) begin
                    pcLoad     = 1'b1;
                    pcLoadVal  = RESET_PC;
                    haltPend_d = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    // Registered bus outputs follow the state being entered. iAddr takes the
    // PC's next value so a jump target or restart address is requested on the
    // very edge it is loaded; outside REQ entry it simply holds.
    assign fetch_d  = fetchCodeFor(state_d);
    assign halted_d = (state_d == ST_HALT);
    assign iAddr_d  = (state_d == ST_REQ) ? pcNext : iAddr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iAddr_q    <= '0;
            fetch_q    <= FETCH_IDLE;
            ir_q       <= '0;
            irValid_q  <= 1'b0;
            haltPend_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            iAddr_q    <= iAddr_d;
            fetch_q    <= fetch_d;
            ir_q       <= ir_d;
            irValid_q  <= irValid_d;
            haltPend_q <= haltPend_d;
            halted_q   <= halted_d;
        end
    end

    assign fetchBus.iAddr    = iAddr_q;
    assign fetchBus.FETCH    = fetch_q;
    assign fetchBus.ir       = ir_q;
    assign fetchBus.ir_valid = irValid_q;
    assign fetchBus.pc       = pcCur;
    assign fetchBus.halted   = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit. Two instances share one stimulus and
// one memory image: dutWrap (WRAP_EN=1) and dutNoWrap (WRAP_EN=0). They behave
// identically until the PC reaches the last address. Each has its own model of
// the instruction RAM, which returns mem[iAddr] one clock after a read strobe.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       irAck = 1'b0;
    logic       jumpEn = 1'b0;
    logic [7:0] jumpAddr = 8'h00;

    logic [7:0] mem [256];
    logic [7:0] ramDataA = 8'h00;
    logic [7:0] ramDataB = 8'h00;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_W(8), .DATA_W(8)) busA ();
    instr_fetch_unit_if #(.ADDR_W(8), .DATA_W(8)) busB ();

    assign busA.start     = start;
    assign busA.ir_ack    = irAck;
    assign busA.jump_en   = jumpEn;
    assign busA.jump_addr = jumpAddr;
    assign busA.instr_in  = ramDataA;
    assign busB.start     = start;
    assign busB.ir_ack    = irAck;
    assign busB.jump_en   = jumpEn;
    assign busB.jump_addr = jumpAddr;
    assign busB.instr_in  = ramDataB;

    instr_fetch_unit #(.WRAP_EN(1'b1)) dutWrap (
        .clk      (clk),
        .rst      (rst),
        .fetchBus (busA)
    );

    instr_fetch_unit #(.WRAP_EN(1'b0)) dutNoWrap (
        .clk      (clk),
        .rst      (rst),
        .fetchBus (busB)
    );

    // Instruction RAM models: data appears one clock after the read strobe.
    always @(posedge clk) begin
        if (busA.FETCH == FETCH_READ) ramDataA <= mem[busA.iAddr];
    end

    always @(posedge clk) begin
        if (busB.FETCH == FETCH_READ) ramDataB <= mem[busB.iAddr];
    end

    // Hard bound on simulated time.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic j,
                                 input logic [7:0] ja);
        start    = s;
        irAck    = a;
        jumpEn   = j;
        jumpAddr = ja;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0]    = 8'h01;
        mem[1]    = 8'h02;
        mem[2]    = 8'h03;
        mem[3]    = 8'h04;
        mem[4]    = 8'h05;
        mem[5]    = 8'h06;
        mem[8'h40] = 8'h11;
        mem[8'hFF] = 8'h22;

        // Reset state while reset is held.
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        tick();
        checkOutput("rst_pc",       busA.pc,       8'h00);
        checkOutput("rst_iAddr",    busA.iAddr,    8'h00);
        checkOutput("rst_FETCH",    busA.FETCH,    2'b00);
        checkOutput("rst_ir",       busA.ir,       8'h00);
        checkOutput("rst_ir_valid", busA.ir_valid, 1'b0);
        checkOutput("rst_halted",   busA.halted,   1'b0);
        rst = 1'b0;
        tick();
        checkOutput("idle_FETCH",   busA.FETCH,    2'b00);

        // Sequential fetch of 01..05 with decode acking immediately.
        $display("[TB] sequential fetch");
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checkOutput("seq_req_FETCH",  busA.FETCH,    2'b01);
            checkOutput("seq_req_iAddr",  busA.iAddr,    k);
            checkOutput("seq_req_valid",  busA.ir_valid, 1'b0);
            tick();
            checkOutput("seq_wait_FETCH", busA.FETCH,    2'b00);
            tick();
            checkOutput("seq_valid_ir",   busA.ir,       k + 1);
            checkOutput("seq_valid_flag", busA.ir_valid, 1'b1);
            checkOutput("seq_valid_pc",   busA.pc,       k + 1);
            checkOutput("seq_valid_FETCH", busA.FETCH,   2'b00);
            if (k < 4) tick();
        end

        // Decode stalls for 5 cycles: everything holds.
        $display("[TB] decode stall");
        irAck = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("stall_ir",    busA.ir,       8'h05);
            checkOutput("stall_valid", busA.ir_valid, 1'b1);
            checkOutput("stall_FETCH", busA.FETCH,    2'b00);
            checkOutput("stall_pc",    busA.pc,       8'h05);
        end
        irAck = 1'b1;
        tick();
        checkOutput("stall_ack_FETCH", busA.FETCH, 2'b01);
        checkOutput("stall_ack_iAddr", busA.iAddr, 8'h05);
        irAck = 1'b0;
        tick();
        tick();
        checkOutput("stall_next_ir", busA.ir, 8'h06);
        checkOutput("stall_next_pc", busA.pc, 8'h06);

        // jump_en without ir_ack is ignored.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h80);
        tick();
        checkOutput("jmp_noack_pc",    busA.pc,       8'h06);
        checkOutput("jmp_noack_valid", busA.ir_valid, 1'b1);
        checkOutput("jmp_noack_FETCH", busA.FETCH,    2'b00);

        // Jump back to 01 so that ir=02 with pc=2, then jump to 40.
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h01);
        tick();
        checkOutput("jmp1_iAddr", busA.iAddr, 8'h01);
        checkOutput("jmp1_pc",    busA.pc,    8'h01);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        tick();
        checkOutput("jmp1_ir", busA.ir, 8'h02);
        checkOutput("jmp1_pc_after", busA.pc, 8'h02);

        $display("[TB] jump to 40");
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h40);
        tick();
        checkOutput("jmp40_FETCH", busA.FETCH, 2'b01);
        checkOutput("jmp40_iAddr", busA.iAddr, 8'h40);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        tick();
        checkOutput("jmp40_ir", busA.ir, 8'h11);
        checkOutput("jmp40_pc", busA.pc, 8'h41);

        // Halt opcode at address 3.
        $display("[TB] halt opcode");
        mem[3] = 8'hFF;
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h03);
        tick();
        checkOutput("halt_req_iAddr", busA.iAddr, 8'h03);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        tick();
        checkOutput("halt_cap_ir",     busA.ir,       8'hFF);
        checkOutput("halt_cap_pc",     busA.pc,       8'h03);
        checkOutput("halt_cap_valid",  busA.ir_valid, 1'b1);
        checkOutput("halt_cap_halted", busA.halted,   1'b0);
        irAck = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checkOutput("halt_halted", busA.halted,   1'b1);
            checkOutput("halt_FETCH",  busA.FETCH,    2'b00);
            checkOutput("halt_valid",  busA.ir_valid, 1'b0);
            checkOutput("halt_pc",     busA.pc,       8'h03);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        start = 1'b0;
        checkOutput("restart_iAddr",  busA.iAddr,  8'h00);
        checkOutput("restart_FETCH",  busA.FETCH,  2'b01);
        checkOutput("restart_halted", busA.halted, 1'b0);
        checkOutput("restart_pc",     busA.pc,     8'h00);
        tick();
        tick();
        checkOutput("restart_ir", busA.ir, 8'h01);
        checkOutput("restart_pc_after", busA.pc, 8'h01);

        // Last address: wrap on one instance, halt on the other.
        $display("[TB] end of memory");
        applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF);
        tick();
        checkOutput("top_iAddr_wrap",   busA.iAddr, 8'hFF);
        checkOutput("top_iAddr_nowrap", busB.iAddr, 8'hFF);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        tick();
        checkOutput("top_ir_wrap",   busA.ir, 8'h22);
        checkOutput("top_pc_wrap",   busA.pc, 8'h00);
        checkOutput("top_ir_nowrap", busB.ir, 8'h22);
        checkOutput("top_pc_nowrap", busB.pc, 8'hFF);
        irAck = 1'b1;
        tick();
        checkOutput("wrap_FETCH",      busA.FETCH,  2'b01);
        checkOutput("wrap_iAddr",      busA.iAddr,  8'h00);
        checkOutput("wrap_halted",     busA.halted, 1'b0);
        checkOutput("nowrap_halted",   busB.halted, 1'b1);
        checkOutput("nowrap_FETCH",    busB.FETCH,  2'b00);
        irAck = 1'b0;

        // Reset pulse while dutWrap waits on the RAM.
        $display("[TB] reset mid-fetch");
        tick();
        checkOutput("pre_rst_FETCH", busA.FETCH, 2'b00);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_pc",       busA.pc,       8'h00);
        checkOutput("mid_rst_iAddr",    busA.iAddr,    8'h00);
        checkOutput("mid_rst_FETCH",    busA.FETCH,    2'b00);
        checkOutput("mid_rst_ir",       busA.ir,       8'h00);
        checkOutput("mid_rst_valid",    busA.ir_valid, 1'b0);
        checkOutput("mid_rst_halted",   busA.halted,   1'b0);
        checkOutput("mid_rst_halted_b", busB.halted,   1'b0);
        #2;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            checkOutput("post_rst_valid", busA.ir_valid, 1'b0);
            checkOutput("post_rst_ir",    busA.ir,       8'h00);
            checkOutput("post_rst_FETCH", busA.FETCH,    2'b00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
